iir_stim_harness: RTL and testbench
===================================

# iir_stim_harness

Synthesizable stimulus and capture harness for the 12-bit direct-form IIR filter block. A source generates a pseudo-random sample stream with periodic valid gaps and drives constant filter coefficients. A sink counts and checksums the filter outputs. A sequencer raises a sticky end-of-run flag once a programmed number of samples has been sent and a drain window has elapsed.

## Interface
- NB, 12, sample/coefficient width
- N_SAMPLES, 16, samples emitted per run (1..65535)
- GAP_PERIOD, 8, one idle cycle per GAP_PERIOD RUN cycles; 0 = no gaps
- DRAIN_CYCLES, 4, cycles waited after the last sample before end_sim
- SEED, 12'hACE, LFSR seed (nonzero)
- B0/B1/B2, 12'h0D3/12'h1A6/12'h0D3, numerator coefficients
- A1/A2, 12'hA4C/12'h2B6, denominator coefficients
- Ports:
  - clock  in  1  single clock, all logic rising-edge
  - reset  in  1  synchronous, active-high
  - start  in  1  begin a run (sampled in IDLE only)
  - dOut  out  NB  sample to filter
  - vOut  out  1  dOut valid
  - b  out  3*NB  {B2,B1,B0}
  - a  out  2*NB  {A2,A1}
  - dIn  in  NB  filter output
  - vIn  in  1  dIn valid
  - end_sim  out  1  run complete, sticky until reset
  - sink_count  out  16  number of vIn beats captured
  - sink_sum  out  32  running checksum of captured outputs

## Operation
- Sequencer states: IDLE → RUN → DRAIN → DONE.
  - IDLE → RUN when start=1.
  - RUN → DRAIN in the cycle after the N_SAMPLES-th sample is emitted.
  - DRAIN → DONE after DRAIN_CYCLES cycles.
  - DONE holds until reset.
- start outside IDLE is ignored.
- Gap rule in RUN: cycle counter c starts at 0 on RUN entry. vOut=0 when GAP_PERIOD≠0 and c mod GAP_PERIOD = GAP_PERIOD−1; otherwise vOut=1.
- Sample values:
  - 12-bit Fibonacci LFSR, taps 11,10,9,3: next = {state[10:0], s11^s10^s9^s3}.
  - The first emitted sample is SEED.
  - The LFSR advances only on emitted samples.
  - dOut holds its last value while vOut=0.
- b and a are constant, driven combinationally from parameters, valid in every state including reset.
- Sink:
  - Active in every state.
  - On each vIn=1 cycle, sink_count increments, saturating at 16'hFFFF.
  - On the same cycle, sink_sum = rotl1(sink_sum) ^ sign_extend32(dIn).
  - vIn=0 leaves the sink unchanged.
- end_sim = (state == DONE).

## Timing
- Reset values: dOut=0, vOut=0, end_sim=0, sink_count=0, sink_sum=0, state=IDLE, LFSR=SEED.
- Reset asserted mid-run aborts immediately at the next edge; no partial flag survives.
- All outputs except b and a are registered.
- start high at edge t: state is RUN after t, and the first sample appears with vOut=1 after edge t+1.
- The gap counter and sample counter share the RUN entry time. The total RUN length in cycles is N_SAMPLES plus the number of gap cycles.
- end_sim rises exactly DRAIN_CYCLES+1 edges after the edge that registers the final vOut=1.
- vIn during IDLE or DONE is still captured.

## Structure
- Shared package iir_pkg holds:
  - NB
  - the default coefficient constants
  - the state enum (IDLE/RUN/DRAIN/DONE)
  - the LFSR tap mask
- Natural split: sub-module stim_source (sequencer + LFSR + gap logic); the sink stays inline in the top.

## Test plan
- Reset, then start pulse: first vOut=1 beat carries dOut=0xACE, the next carries 0x59D; b=0x0D31A60D3 and a=0x2B6A4C throughout.
- Defaults (N=16, GAP=8): vOut pattern 7 high, 1 low, 7 high, 1 low, 2 high; then vOut=0; end_sim rises 5 edges after the last sample and stays high.
- GAP_PERIOD=0, N_SAMPLES=3: exactly 3 consecutive valid beats, then end_sim after DRAIN.
- Sink: vIn beats dIn=0x001 then dIn=0x800 → sink_count=2, sink_sum=0xFFFFF802. A vIn=0 cycle in between changes nothing.
- Assert reset during RUN after 5 samples: all outputs return to reset values. A new start restarts from sample 0xACE and count 0.
- start pulses during RUN and DONE: no effect on the sample count or end_sim.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, coefficient defaults, sequencer states and LFSR helper for the IIR harness
package iir_pkg;
  localparam int NB = 12;
  localparam logic [NB-1:0] B0_DEF = 12'h0D3;
  localparam logic [NB-1:0] B1_DEF = 12'h1A6;
  localparam logic [NB-1:0] B2_DEF = 12'h0D3;
  localparam logic [NB-1:0] A1_DEF = 12'hA4C;
  localparam logic [NB-1:0] A2_DEF = 12'h2B6;
  localparam logic [NB-1:0] LFSR_TAPS = 12'hE08;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [NB-1:0] lfsr_next(input logic [NB-1:0] s);
    return {s[NB-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/iir_stim_harness_stim_source.sv
// stim_source: run sequencer, gapped valid pattern and LFSR sample generator
module stim_source
  import iir_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int GAP_PERIOD = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter logic [NB-1:0] SEED = 12'hACE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [NB-1:0] sample,
  output logic          sample_valid,
  output logic          done
);
  state_t state, state_nx;
  logic [15:0] c, n, d;
  logic [NB-1:0] lfsr;
  logic gap, emit;
  always_comb begin
    gap = (GAP_PERIOD != 0) && (c == 16'(GAP_PERIOD - 1));
    emit = (state == RUN) && !gap;
    state_nx = state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? ((emit && n == 16'(N_SAMPLES - 1)) ? DRAIN : RUN) :
               state == DRAIN ? ((d == 16'(DRAIN_CYCLES)) ? DONE : DRAIN) : DONE;
  end
  // done is the registered decode of the next state so it tracks DONE exactly
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      c <= '0;
      n <= '0;
      d <= '0;
      lfsr <= SEED;
      sample <= '0;
      sample_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state_nx == DONE;
      sample_valid <= emit;
      c <= state == RUN ? (gap ? '0 : c + 16'd1) : '0;
      d <= state == DRAIN ? d + 16'd1 : '0;
      if (emit) begin
        sample <= lfsr;
        lfsr <= lfsr_next(lfsr);
        n <= n + 16'd1;
      end
    end
  end
endmodule

// File: rtl/iir_stim_harness.sv
// iir_stim_harness: drives the IIR filter with gapped LFSR samples and checksums its outputs
module iir_stim_harness
  import iir_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int GAP_PERIOD = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter logic [NB-1:0] SEED = 12'hACE,
  parameter logic [NB-1:0] B0 = B0_DEF,
  parameter logic [NB-1:0] B1 = B1_DEF,
  parameter logic [NB-1:0] B2 = B2_DEF,
  parameter logic [NB-1:0] A1 = A1_DEF,
  parameter logic [NB-1:0] A2 = A2_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic [NB-1:0]   dOut,
  output logic            vOut,
  output logic [3*NB-1:0] b,
  output logic [2*NB-1:0] a,
  input  logic [NB-1:0]   dIn,
  input  logic            vIn,
  output logic            end_sim,
  output logic [15:0]     sink_count,
  output logic [31:0]     sink_sum
);
  assign b = {B2, B1, B0};
  assign a = {A2, A1};
  stim_source #(
    .N_SAMPLES(N_SAMPLES),
    .GAP_PERIOD(GAP_PERIOD),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .SEED(SEED)
  ) u_src (
    .clock(clock),
    .reset(reset),
    .start(start),
    .sample(dOut),
    .sample_valid(vOut),
    .done(end_sim)
  );
  // sink runs in every sequencer state
  always_ff @(posedge clock) begin
    if (reset) begin
      sink_count <= '0;
      sink_sum <= '0;
    end else if (vIn) begin
      sink_count <= sink_count == 16'hFFFF ? sink_count : sink_count + 16'd1;
      sink_sum <= {sink_sum[30:0], sink_sum[31]} ^ {{(32-NB){dIn[NB-1]}}, dIn};
    end
  end
endmodule

// File: tb/tb_iir_stim_harness.sv
// tb_iir_stim_harness: scoreboard bench for the default harness plus a gapless 3-sample variant
module tb_iir_stim_harness;
  logic clock = 0, reset = 1, start = 0, vIn = 0;
  logic [11:0] dIn = 0;
  logic [11:0] dOut, d3;
  logic vOut, end_sim, v3, e3;
  logic [35:0] b, b3;
  logic [23:0] a, a3;
  logic [15:0] sink_count, c3;
  logic [31:0] sink_sum, s3;
  int vectors = 0, miscompares = 0, popped = 0;
  logic [11:0] q[$];
  logic [11:0] exp3[3] = '{12'hACE, 12'h59D, 12'hB3A};

  always #5 clock = ~clock;

  iir_stim_harness dut (
    .clock(clock), .reset(reset), .start(start), .dOut(dOut), .vOut(vOut),
    .b(b), .a(a), .dIn(dIn), .vIn(vIn), .end_sim(end_sim),
    .sink_count(sink_count), .sink_sum(sink_sum)
  );

  iir_stim_harness #(.N_SAMPLES(3), .GAP_PERIOD(0)) dut3 (
    .clock(clock), .reset(reset), .start(start), .dOut(d3), .vOut(v3),
    .b(b3), .a(a3), .dIn(12'h000), .vIn(1'b0), .end_sim(e3),
    .sink_count(c3), .sink_sum(s3)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] step(input logic [11:0] x);
    return {x[10:0], x[11] ^ x[10] ^ x[9] ^ x[3]};
  endfunction

  task automatic push_run();
    logic [11:0] x = 12'hACE;
    for (int i = 0; i < 16; i++) begin
      q.push_back(x);
      x = step(x);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_dOut", dOut, 0);
    check("rst_vOut", vOut, 0);
    check("rst_end_sim", end_sim, 0);
    check("rst_sink_count", sink_count, 0);
    check("rst_sink_sum", sink_sum, 0);
    check("rst_end_sim_n3", e3, 0);
  endtask

  task automatic run_window();
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check("vOut", vOut, (i < 18) && (i % 8 != 7));
      check("end_sim", end_sim, i >= 22);
      check("vOut_n3", v3, i < 3);
      check("end_sim_n3", e3, i >= 7);
      if (i < 3) check("dOut_n3", d3, exp3[i]);
      start = (i == 3) || (i == 25);
    end
    start = 0;
  endtask

  // monitor: every valid beat must match the head of the expected queue
  initial forever begin
    @(posedge clock);
    #1;
    if (vOut) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dOut_unexpected: got %0h expected no beat at %0t", dOut, $time);
      end else check("dOut", dOut, q.pop_front());
      popped++;
    end
  end

  initial begin
    int base, k;
    repeat (3) @(negedge clock);
    check_reset_vals();
    check("b", b, 36'h0D31A60D3);
    check("a", a, 24'h2B6A4C);
    reset = 0;
    vIn = 1; dIn = 12'h001;
    @(negedge clock);
    check("sink_count_1", sink_count, 1);
    check("sink_sum_1", sink_sum, 32'h1);
    vIn = 0; dIn = 12'h7FF;
    @(negedge clock);
    check("sink_count_gap", sink_count, 1);
    check("sink_sum_gap", sink_sum, 32'h1);
    vIn = 1; dIn = 12'h800;
    @(negedge clock);
    vIn = 0;
    check("sink_count_2", sink_count, 2);
    check("sink_sum_2", sink_sum, 32'hFFFFF802);
    push_run();
    pulse_start();
    run_window();
    check("sink_count_after_run", sink_count, 2);
    check("b_done", b, 36'h0D31A60D3);
    check("a_done", a, 24'h2B6A4C);
    check("pending_run1", q.size(), 0);
    q.delete();
    push_run();
    @(negedge clock) reset = 1;
    @(negedge clock) reset = 0;
    check("end_sim_cleared", end_sim, 0);
    pulse_start();
    base = popped;
    k = 0;
    while (popped < base + 5 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("five_samples_seen", popped >= base + 5, 1);
    reset = 1;
    @(negedge clock);
    check_reset_vals();
    reset = 0;
    q.delete();
    push_run();
    pulse_start();
    run_window();
    check("pending_run2", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
